tmds_decoder: RTL and testbench

- Receive-side counterpart of tmds_encoder: takes one 10-bit TMDS character per cycle and recovers 8-bit pixel data, the 2-bit control value and the video-enable flag.
- Flags characters the encoder could never emit, and maintains a character-lock state from control-period tokens.
- Used in loopback benches and on-chip checkers that sit between tmds_encoder output and tmds_serializer input, one instance per channel (blue/green/red).

---
 rtl/tmds_decoder_pkg.sv | 23 ++
 rtl/tmds_decoder_symbol_decode.sv | 45 ++++
 rtl/tmds_decoder.sv | 196 +++++++++++++++++++
 tb/tb_tmds_decoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_decoder_pkg.sv
// Shared TMDS definitions: control tokens, lock-state encoding and popcount helper.
// Used by tmds_decoder and tmds_encoder.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_decoder_symbol_decode.sv
// Combinational TMDS character decode: control-token match, data recovery and
// check of the encoder's XOR/XNOR transition choice.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] i_tmds,
  output logic [7:0] o_q,
  output logic       o_ve,
  output logic [1:0] o_control,
  output logic       o_choice_err
);

  logic [7:0] w_d;
  logic [7:0] w_q;
  logic [3:0] w_n;
  logic       w_xnor;

  always_comb begin
    w_d    = i_tmds[9] ? ~i_tmds[7:0] : i_tmds[7:0];
    w_q    = '0;
    w_q[0] = w_d[0];
    for (int unsigned i = 1; i < 8; i++)
      w_q[i] = i_tmds[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
    w_n    = popcount8(w_q);
    // the encoder picks XNOR on this condition and then sends bit 8 low
    w_xnor = (w_n > 4'd4) || ((w_n == 4'd4) && !w_q[0]);

    o_q          = w_q;
    o_ve         = 1'b1;
    o_control    = '0;
    o_choice_err = (i_tmds[8] == w_xnor);
    case (i_tmds)
      CTRL_TOKEN_00: begin o_ve = 1'b0; o_control = 2'b00; end
      CTRL_TOKEN_01: begin o_ve = 1'b0; o_control = 2'b01; end
      CTRL_TOKEN_10: begin o_ve = 1'b0; o_control = 2'b10; end
      CTRL_TOKEN_11: begin o_ve = 1'b0; o_control = 2'b11; end
      default: ;
    endcase
    if (!o_ve) begin
      o_q          = '0;
      o_choice_err = 1'b0;
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS receive decoder: 2-stage pipeline, symbol error detection, lock FSM and
// saturating error counter. Define TMDS_DECODER_DISPARITY_CHECK_EN to also check bit 9.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 8,
  parameter int unsigned ERR_LIMIT  = 4,
  parameter int unsigned ERR_CNT_W  = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 valid_in,
  input  logic [9:0]           tmds_in,
  output logic                 valid_out,
  output logic [7:0]           data_out,
  output logic [1:0]           control_out,
  output logic                 ve_out,
  output logic                 symbol_err_out,
  output logic                 locked_out,
  output logic [ERR_CNT_W-1:0] err_count_out
);

  localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned ERR_W = $clog2(ERR_LIMIT + 1);

  logic                 r_valid_s1;
  logic [9:0]           r_tmds_s1;
  logic                 r_valid_out;
  logic [7:0]           r_data;
  logic [1:0]           r_control;
  logic                 r_ve;
  logic                 r_sym_err;
  logic                 r_locked;
  logic [ERR_CNT_W-1:0] r_err_count;
  lock_state_t          r_state;
  logic [RUN_W-1:0]     r_run;
  logic [ERR_W-1:0]     r_err_run;

  logic [7:0]       w_q;
  logic             w_ve;
  logic [1:0]       w_control;
  logic             w_choice_err;
  logic             w_err;
  logic [RUN_W-1:0] w_run_inc;
  logic [ERR_W-1:0] w_err_inc;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_valid_s1 <= 1'b0;
      r_tmds_s1  <= '0;
    end else begin
      r_valid_s1 <= valid_in;
      if (valid_in) r_tmds_s1 <= tmds_in;
    end
  end

  tmds_symbol_decode u_symbol_decode (
    .i_tmds       (r_tmds_s1),
    .o_q          (w_q),
    .o_ve         (w_ve),
    .o_control    (w_control),
    .o_choice_err (w_choice_err)
  );

`ifdef TMDS_DECODER_DISPARITY_CHECK_EN
  logic [4:0] r_disp;
  logic [4:0] w_disp_next;
  logic [4:0] w_bal;
  logic [7:0] w_dm;
  logic [3:0] w_n1;
  logic       w_exp9;
  logic       w_disp_err;

  // Mirror of the encoder's running-disparity rule; bit 4 of r_disp is the sign.
  always_comb begin
    w_dm        = r_tmds_s1[9] ? ~r_tmds_s1[7:0] : r_tmds_s1[7:0];
    w_n1        = popcount8(w_dm);
    w_bal       = {w_n1, 1'b0} - 5'd8;
    w_exp9      = 1'b0;
    w_disp_next = r_disp;
    if ((r_disp == '0) || (w_n1 == 4'd4)) begin
      w_exp9      = ~r_tmds_s1[8];
      w_disp_next = r_tmds_s1[8] ? (r_disp + w_bal) : (r_disp - w_bal);
    end else if ((!r_disp[4] && (w_n1 > 4'd4)) || (r_disp[4] && (w_n1 < 4'd4))) begin
      w_exp9      = 1'b1;
      w_disp_next = r_disp + {3'b000, r_tmds_s1[8], 1'b0} - w_bal;
    end else begin
      w_exp9      = 1'b0;
      w_disp_next = r_disp - {3'b000, ~r_tmds_s1[8], 1'b0} + w_bal;
    end
    w_disp_err = w_ve && (w_exp9 != r_tmds_s1[9]);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)         r_disp <= '0;
    else if (r_valid_s1) r_disp <= w_ve ? w_disp_next : '0;
  end

  assign w_err = w_choice_err | w_disp_err;
`else
  assign w_err = w_choice_err;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_valid_out <= 1'b0;
      r_data      <= '0;
      r_control   <= '0;
      r_ve        <= 1'b0;
      r_sym_err   <= 1'b0;
    end else begin
      r_valid_out <= r_valid_s1;
      r_sym_err   <= r_valid_s1 & w_err;
      if (r_valid_s1) begin
        r_ve   <= w_ve;
        r_data <= w_ve ? w_q : '0;
        if (!w_ve) r_control <= w_control;
      end
    end
  end

  assign w_run_inc = r_run + RUN_W'(1);
  assign w_err_inc = r_err_run + ERR_W'(1);

  // Lock FSM consumes the registered stage-2 character, so locked_out trails valid_out by one cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= UNLOCKED;
      r_run     <= '0;
      r_err_run <= '0;
      r_locked  <= 1'b0;
    end else if (r_valid_out) begin
      case (r_state)
        UNLOCKED: begin
          if (!r_ve) begin
            r_run     <= RUN_W'(1);
            r_err_run <= '0;
            if (LOCK_COUNT <= 1) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_state <= ACQUIRE;
            end
          end
        end
        ACQUIRE: begin
          if (!r_ve) begin
            r_run <= w_run_inc;
            if (w_run_inc >= RUN_W'(LOCK_COUNT)) begin
              r_state   <= LOCKED;
              r_locked  <= 1'b1;
              r_err_run <= '0;
            end
          end else begin
            r_run   <= '0;
            r_state <= UNLOCKED;
          end
        end
        LOCKED: begin
          if (r_sym_err) begin
            if (w_err_inc >= ERR_W'(ERR_LIMIT)) begin
              r_state   <= UNLOCKED;
              r_locked  <= 1'b0;
              r_err_run <= '0;
              r_run     <= '0;
            end else begin
              r_err_run <= w_err_inc;
            end
          end else begin
            r_err_run <= '0;
          end
        end
        default: begin
          r_state  <= UNLOCKED;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      r_err_count <= '0;
    else if (r_valid_out && r_sym_err && (r_err_count != '1))
      r_err_count <= r_err_count + ERR_CNT_W'(1);
  end

  assign valid_out      = r_valid_out;
  assign data_out       = r_data;
  assign control_out    = r_control;
  assign ve_out         = r_ve;
  assign symbol_err_out = r_sym_err;
  assign locked_out     = r_locked;
  assign err_count_out  = r_err_count;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed self-checking bench for tmds_decoder (default build).
module tb_tmds_decoder;

  logic        clk_in;
  logic        rst_in;
  logic        valid_in;
  logic [9:0]  tmds_in;
  logic        valid_out;
  logic [7:0]  data_out;
  logic [1:0]  control_out;
  logic        ve_out;
  logic        symbol_err_out;
  logic        locked_out;
  logic [15:0] err_count_out;

  int n_tests = 0;
  int n_fail  = 0;
  int enc_cnt = 0;

  localparam logic [9:0] TOK00   = 10'b1101010100;
  localparam logic [9:0] TOK01   = 10'b0010101011;
  localparam logic [9:0] TOK10   = 10'b0101010100;
  localparam logic [9:0] TOK11   = 10'b1010101011;
  localparam logic [9:0] D00     = 10'b0100000000;
  localparam logic [9:0] DFF     = 10'b1000000000;
  localparam logic [9:0] DFF_BAD = 10'b0101010101;

  tmds_decoder #(
    .LOCK_COUNT (8),
    .ERR_LIMIT  (4),
    .ERR_CNT_W  (16)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .valid_in       (valid_in),
    .tmds_in        (tmds_in),
    .valid_out      (valid_out),
    .data_out       (data_out),
    .control_out    (control_out),
    .ve_out         (ve_out),
    .symbol_err_out (symbol_err_out),
    .locked_out     (locked_out),
    .err_count_out  (err_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One character, then idle; returns on the negedge where its decode is visible.
  task automatic xfer(input logic [9:0] c);
    @(negedge clk_in);
    valid_in = 1'b1;
    tmds_in  = c;
    @(negedge clk_in);
    valid_in = 1'b0;
    tmds_in  = '0;
    @(negedge clk_in);
  endtask

  // Reference DVI TMDS encoder with running disparity.
  function automatic logic [9:0] tmds_enc(input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] o;
    logic       use_xnor;
    int         n1d, n1, n0;
    n1d = 0;
    for (int i = 0; i < 8; i++) n1d += int'(d[i]);
    use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
    n0 = 8 - n1;
    if (enc_cnt == 0 || n1 == n0) begin
      o = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      enc_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
    end else if ((enc_cnt > 0 && n1 > n0) || (enc_cnt < 0 && n0 > n1)) begin
      o = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += (qm[8] ? 2 : 0) + n0 - n1;
    end else begin
      o = {1'b0, qm[8], qm[7:0]};
      enc_cnt += (qm[8] ? 0 : -2) + n1 - n0;
    end
    return o;
  endfunction

  initial begin
    logic [9:0] toks [4];
    toks[0] = TOK00; toks[1] = TOK01; toks[2] = TOK10; toks[3] = TOK11;

    clk_in = 1'b0; rst_in = 1'b0; valid_in = 1'b0; tmds_in = '0;
    #3;
    check_eq("rst_valid",   valid_out, 0);
    check_eq("rst_data",    data_out, 0);
    check_eq("rst_ctrl",    control_out, 0);
    check_eq("rst_ve",      ve_out, 0);
    check_eq("rst_err",     symbol_err_out, 0);
    check_eq("rst_locked",  locked_out, 0);
    check_eq("rst_errcnt",  err_count_out, 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;

    // First token, with the 2-cycle latency checked explicitly
    @(negedge clk_in);
    valid_in = 1'b1; tmds_in = TOK00;
    @(negedge clk_in);
    valid_in = 1'b0; tmds_in = '0;
    check_eq("lat1_valid", valid_out, 0);
    @(negedge clk_in);
    check_eq("tok00_valid",  valid_out, 1);
    check_eq("tok00_ve",     ve_out, 0);
    check_eq("tok00_ctrl",   control_out, 2'b00);
    check_eq("tok00_err",    symbol_err_out, 0);
    check_eq("tok00_locked", locked_out, 0);

    // Data character drops ACQUIRE back to UNLOCKED
    xfer(D00);
    check_eq("d00_data", data_out, 8'h00);
    check_eq("d00_ve",   ve_out, 1);
    check_eq("d00_err",  symbol_err_out, 0);

    for (int i = 0; i < 8; i++) begin
      xfer(TOK10);
      check_eq("lock_ctrl", control_out, 2'b10);
      check_eq("lock_pre",  locked_out, 0);
    end
    @(negedge clk_in);
    check_eq("lock_rise", locked_out, 1);

    xfer(DFF);
    check_eq("dff_data",      data_out, 8'hFF);
    check_eq("dff_ve",        ve_out, 1);
    check_eq("dff_ctrl_hold", control_out, 2'b10);
    check_eq("dff_err",       symbol_err_out, 0);
    @(negedge clk_in);
    check_eq("lock_after_data", locked_out, 1);
    xfer(TOK10);
    @(negedge clk_in);
    check_eq("lock_after_tok", locked_out, 1);

    for (int i = 0; i < 4; i++) begin
      xfer(toks[i]);
      check_eq("tok_ctrl", control_out, i);
      check_eq("tok_ve",   ve_out, 0);
      check_eq("tok_data", data_out, 0);
    end

    enc_cnt = 0;
    for (int b = 0; b < 256; b++) begin
      xfer(tmds_enc(8'(b)));
      check_eq("enc_data", data_out, b);
      check_eq("enc_err",  symbol_err_out, 0);
    end
    @(negedge clk_in);
    check_eq("enc_errcnt", err_count_out, 0);
    check_eq("enc_locked", locked_out, 1);

    xfer(DFF_BAD);
    check_eq("bad_data", data_out, 8'hFF);
    check_eq("bad_err",  symbol_err_out, 1);
    @(negedge clk_in);
    check_eq("bad_pulse",  symbol_err_out, 0);
    check_eq("bad_errcnt", err_count_out, 1);
    check_eq("bad_locked", locked_out, 1);
    xfer(D00);
    check_eq("good_err", symbol_err_out, 0);

    for (int i = 0; i < 3; i++) xfer(DFF_BAD);
    xfer(D00);
    @(negedge clk_in);
    check_eq("three_locked", locked_out, 1);
    check_eq("three_errcnt", err_count_out, 4);

    for (int i = 0; i < 4; i++) begin
      xfer(DFF_BAD);
      @(negedge clk_in);
      check_eq("four_locked", locked_out, (i < 3) ? 1 : 0);
      check_eq("four_errcnt", err_count_out, 5 + i);
    end

    // Asynchronous reset in the middle of a token stream
    @(negedge clk_in);
    valid_in = 1'b1; tmds_in = TOK01;
    repeat (3) @(negedge clk_in);
    check_eq("pre_rst_ctrl", control_out, 2'b01);
    #2 rst_in = 1'b0;
    #1;
    check_eq("arst_valid",  valid_out, 0);
    check_eq("arst_data",   data_out, 0);
    check_eq("arst_ctrl",   control_out, 0);
    check_eq("arst_ve",     ve_out, 0);
    check_eq("arst_err",    symbol_err_out, 0);
    check_eq("arst_locked", locked_out, 0);
    check_eq("arst_errcnt", err_count_out, 0);
    @(negedge clk_in);
    valid_in = 1'b0; tmds_in = '0;
    rst_in = 1'b1;
    @(negedge clk_in);
    check_eq("post_rst_idle", valid_out, 0);
    valid_in = 1'b1; tmds_in = TOK11;
    @(negedge clk_in);
    valid_in = 1'b0; tmds_in = '0;
    check_eq("post_rst_lat", valid_out, 0);
    @(negedge clk_in);
    check_eq("post_rst_valid", valid_out, 1);
    check_eq("post_rst_ctrl",  control_out, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
